// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial a-b-bin controller around one full_subtractor cell (optional flags: SERIAL_SUB_FLAGS_EN)

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic br
);
    assign d  = x ^ y ^ bi;
    assign br = (~x & y) | (~(x ^ y) & bi);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] diff_r;
    logic             borrow;
    logic             bout_r;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             b_bit;
    logic [WIDTH:0]   diff_shift;

    full_subtractor u_fs (
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .bi (borrow),
        .d  (d_bit),
        .br (b_bit)
    );

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign diff_shift = {d_bit, diff_r};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign diff      = diff_r;
    assign bout      = bout_r;

`ifdef SERIAL_SUB_FLAGS_EN
    logic zero_r;
    logic ovf_r;
    assign zero = zero_r;
    assign ovf  = ovf_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            diff_r <= '0;
            borrow <= 1'b0;
            bout_r <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_a   <= a;
                        sh_b   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    borrow <= b_bit;
                    diff_r <= diff_shift[WIDTH:1];
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bout_r <= b_bit;
`ifdef SERIAL_SUB_FLAGS_EN
                        zero_r <= (diff_shift[WIDTH:1] == '0);
                        // borrow currently holds the borrow into the MSB
                        ovf_r  <= borrow ^ b_bit;
`endif
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
